// File: rtl/mptw_pipeline_pkg.sv
// mptw_pipeline_pkg: shared flush/status encodings, controller states and default parameters.
package mptw_pipeline_pkg;
    typedef enum logic [1:0] {
        MPT_FLUSH_NONE = 2'd0,
        MPT_FLUSH_SOFT = 2'd1,
        MPT_FLUSH_HARD = 2'd2
    } mptw_flush_ctrl_e;
    typedef enum logic {
        MPT_FLUSHED_NONE      = 1'b0,
        MPT_FLUSHED_COMPLETED = 1'b1
    } mptw_flush_status_e;
    typedef logic [1:0] pctrl_state_e;
    localparam pctrl_state_e PCTRL_IDLE  = 2'd0;
    localparam pctrl_state_e PCTRL_DRAIN = 2'd1;
    localparam pctrl_state_e PCTRL_FLUSH = 2'd2;
    localparam pctrl_state_e PCTRL_DONE  = 2'd3;
    localparam int FCTRL_W           = $bits(mptw_flush_ctrl_e);
    localparam int FSTAT_W           = $bits(mptw_flush_status_e);
    localparam int DEF_NUM_STAGES    = 4;
    localparam int DEF_FLUSH_CYCLES  = 1;
    localparam int DEF_DRAIN_TIMEOUT = 64;
    localparam int DEF_CNT_W         = 32;
endpackage

// File: rtl/mptw_sat_counter.sv
// mptw_sat_counter: up-counter with synchronous clear that holds at all-ones.
module mptw_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr_i ? '0 : (en_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
    assign cnt_o = cnt_q;
endmodule

// File: rtl/mptw_pipeline_flush_ctrl.sv
// mptw_pipeline_flush_ctrl: drain/flush sequencer and status aggregator for the walker pipeline.
// Define MPTW_PCTRL_STALL_CNT_EN to add the saturating stall counter output stall_cnt_o.
module mptw_pipeline_flush_ctrl
    import mptw_pipeline_pkg::*;
#(
    parameter int NUM_STAGES    = DEF_NUM_STAGES,
    parameter int FLUSH_CYCLES  = DEF_FLUSH_CYCLES,
    parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [FCTRL_W-1:0]            req_type_i,
    output logic [FCTRL_W-1:0]            flush_o,
    input  logic [NUM_STAGES*FSTAT_W-1:0] stage_flushed_i,
    input  logic [NUM_STAGES-1:0]         stage_busy_i,
    input  logic [NUM_STAGES-1:0]         stage_stalled_i,
    output logic                          done_o,
    output logic                          done_timeout_o,
    output logic                          done_err_o,
    output logic                          pipe_busy_o,
    output logic                          pipe_stalled_o
`ifdef MPTW_PCTRL_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]              stall_cnt_o
`endif
);
    localparam int DT_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
    pctrl_state_e        state_q, state_d;
    logic [FCTRL_W-1:0]  type_q, type_d;
    logic [FC_W-1:0]     fcnt_q, fcnt_d;
    logic                to_q, to_d, err_q, err_d;
    logic [DT_W-1:0]     dcnt;
    logic                any_bad;
    assign pipe_busy_o    = |stage_busy_i;
    assign pipe_stalled_o = |stage_stalled_i;
    assign req_ready_o    = state_q == PCTRL_IDLE;
    assign done_o         = state_q == PCTRL_DONE;
    assign done_timeout_o = done_o & to_q;
    assign done_err_o     = done_o & err_q;
    assign flush_o        = state_q == PCTRL_FLUSH ? type_q : MPT_FLUSH_NONE;
    mptw_sat_counter #(.W(DT_W)) u_drain_timer (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (state_q != PCTRL_DRAIN),
        .en_i  (state_q == PCTRL_DRAIN),
        .cnt_o (dcnt)
    );
    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        fcnt_d  = fcnt_q;
        to_d    = to_q;
        err_d   = err_q;
        any_bad = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++)
            any_bad = any_bad | (stage_flushed_i[k*FSTAT_W +: FSTAT_W] != MPT_FLUSHED_COMPLETED);
        case (state_q)
            PCTRL_IDLE: begin
                fcnt_d = '0;
                if (req_valid_i) begin
                    type_d  = req_type_i;
                    state_d = req_type_i == MPT_FLUSH_NONE ? PCTRL_DONE :
                              req_type_i == MPT_FLUSH_SOFT ? PCTRL_DRAIN : PCTRL_FLUSH;
                end
            end
            PCTRL_DRAIN: begin
                // an idle pipe wins over a timeout landing in the same cycle
                if (!pipe_busy_o) begin
                    state_d = PCTRL_FLUSH;
                end else if (dcnt == DT_W'(DRAIN_TIMEOUT - 1)) begin
                    state_d = PCTRL_FLUSH;
                    to_d    = 1'b1;
                    type_d  = MPT_FLUSH_HARD;
                end
            end
            PCTRL_FLUSH: begin
                if (fcnt_q == FC_W'(FLUSH_CYCLES - 1)) begin
                    err_d   = any_bad;
                    fcnt_d  = '0;
                    state_d = PCTRL_DONE;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
            default: begin
                to_d    = 1'b0;
                err_d   = 1'b0;
                state_d = PCTRL_IDLE;
            end
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= PCTRL_IDLE;
            type_q  <= MPT_FLUSH_NONE;
            fcnt_q  <= '0;
            to_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            fcnt_q  <= fcnt_d;
            to_q    <= to_d;
            err_q   <= err_d;
        end
    end
`ifdef MPTW_PCTRL_STALL_CNT_EN
    mptw_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (done_o && type_q == MPT_FLUSH_HARD),
        .en_i  (pipe_stalled_o),
        .cnt_o (stall_cnt_o)
    );
`endif
endmodule
